vdp_super_vram_arbiter: RTL

//  Upstream VRAM port for the super high-res display pipeline. It time-slices one fixed-latency
//  32-bit read / 16-bit write VRAM command port between two users. Display fetches are issued
//  on the FS dot phase and returned as vrm_32. CPU/VDP byte accesses are handshaked and use all

---
 rtl/vdp_super_vram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vdp_super_vram_arbiter.sv
// Shares one fixed-latency VRAM command port between super high-res display fetches
// (FS dot phase) and handshaked CPU/VDP byte accesses (every other slot).
module vdp_super_vram_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_super_high_res,
  input  logic [1:0]  i_dot_phase,
  input  logic        i_display_req,
  input  logic [16:0] i_display_addr,
  output logic [31:0] o_vrm_32,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wr,
  input  logic [17:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_mem_req,
  output logic        o_mem_wr,
  output logic [16:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic [1:0]  o_mem_wmask,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rvalid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } cpu_state_t;

  cpu_state_t             r_state;
  logic                   r_wr;
  logic [17:0]            r_addr;
  logic [7:0]             r_wdata;
  logic                   r_cpu_ack;
  logic [7:0]             r_cpu_rdata;
  logic [31:0]            r_vrm_32;
  logic [MEM_LATENCY-1:0] r_tag_valid;
  logic [MEM_LATENCY-1:0] r_tag_disp;

  logic w_disp_slot;
  logic w_cpu_issue;
  logic w_push;
  logic w_ret_valid;
  logic w_ret_disp;

  assign w_disp_slot = i_super_high_res & (i_dot_phase == 2'd3) & i_display_req;
  assign w_cpu_issue = (r_state == ST_PEND) & ~w_disp_slot;
  assign w_push      = ~i_reset & (w_disp_slot | (w_cpu_issue & ~r_wr));
  // The tag at the end of the shift line is the one the current mem_rvalid belongs to.
  assign w_ret_valid = i_mem_rvalid & r_tag_valid[MEM_LATENCY-1];
  assign w_ret_disp  = r_tag_disp[MEM_LATENCY-1];

  assign o_vrm_32    = r_vrm_32;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = 17'd0;
    o_mem_wdata = 16'd0;
    o_mem_wmask = 2'b00;
    if (i_reset) begin
      o_mem_req = 1'b0;
    end else if (w_disp_slot) begin
      o_mem_req  = 1'b1;
      o_mem_addr = i_display_addr;
    end else if (w_cpu_issue) begin
      o_mem_req  = 1'b1;
      o_mem_wr   = r_wr;
      o_mem_addr = r_addr[17:1];
      if (r_wr) begin
        o_mem_wdata = {r_wdata, r_wdata};
        o_mem_wmask = r_addr[0] ? 2'b10 : 2'b01;
      end else begin
        o_mem_wdata = 16'd0;
      end
    end else begin
      o_mem_req = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag_valid <= '0;
      r_tag_disp  <= '0;
    end else begin
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_disp[i]  <= r_tag_disp[i-1];
      end
      r_tag_valid[0] <= w_push;
      r_tag_disp[0]  <= w_disp_slot;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vrm_32 <= 32'd0;
    end else if (w_ret_valid & w_ret_disp) begin
      r_vrm_32 <= i_mem_rdata;
    end else begin
      r_vrm_32 <= r_vrm_32;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_addr      <= 18'd0;
      r_wdata     <= 8'd0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 8'd0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cpu_req) begin
            r_wr    <= i_cpu_wr;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_cpu_issue) begin
            if (r_wr) begin
              r_cpu_ack <= 1'b1;
              r_state   <= ST_ACK;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_ret_valid & ~w_ret_disp) begin
            r_cpu_rdata <= r_addr[0] ? i_mem_rdata[15:8] : i_mem_rdata[7:0];
            r_cpu_ack   <= 1'b1;
            r_state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
